pe_cmd_feeder: RTL

- Upstream command sequencer for the PE custom-instruction block.
- CPU-side logic pushes (opcode, operand) pairs into an internal FIFO at its own rate.
- The feeder replays each pair onto the PE start/n/dataa/done interface, one command per handshake.
- For read opcodes it captures the PE result and holds it until acknowledged. This decouples Nios II issue timing from PE latency.

---
 rtl/pe_cmd_pkg.sv | 29 ++
 rtl/pe_cmd_fifo.sv | 80 ++++++++
 rtl/pe_cmd_feeder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pe_cmd_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classifiers
// for the PE command feeder and its FIFO.
package pe_cmd_pkg;

   localparam int OPC_W = 3;

   localparam logic [OPC_W-1:0] OP_NOP  = 3'd0;
   localparam logic [OPC_W-1:0] OP_WR1  = 3'd1;
   localparam logic [OPC_W-1:0] OP_WR2  = 3'd2;
   localparam logic [OPC_W-1:0] OP_WR3  = 3'd3;
   localparam logic [OPC_W-1:0] OP_READ = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   function automatic logic is_write(input logic [OPC_W-1:0] op);
      return (op == OP_WR1) || (op == OP_WR2) || (op == OP_WR3);
   endfunction

   // Everything above READ is reserved: popped and flagged, never issued.
   function automatic logic is_reserved(input logic [OPC_W-1:0] op);
      return (op > OP_READ);
   endfunction

endpackage

// File: rtl/pe_cmd_fifo.sv
// Command FIFO: DEPTH entries of {opcode, operand}, registered count/full,
// synchronous flush, frozen entirely while clk_en is low.
module pe_cmd_fifo
   import pe_cmd_pkg::*;
#(
   parameter int W      = 35,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_en,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   input  logic [W-1:0]      wdata,
   output logic [W-1:0]      rdata,
   output logic [ADDR_W:0]   count,
   output logic [ADDR_W:0]   count_nxt,
   output logic              full,
   output logic              empty
);

   logic [W-1:0]      mem_r [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W:0]   count_r;
   logic              full_r;
   logic              push_ok_s;
   logic              pop_ok_s;

   // A push is judged against the registered full flag, never the same-cycle pop.
   assign push_ok_s = push & ~full_r;
   assign pop_ok_s  = pop & (count_r != (ADDR_W+1)'(0));

   // Next occupancy; also exported so the owner can register its busy flag.
   always_comb begin
      count_nxt = count_r;
      if (clear) begin
         count_nxt = (ADDR_W+1)'(0);
      end else if (push_ok_s && !pop_ok_s) begin
         count_nxt = count_r + (ADDR_W+1)'(1);
      end else if (pop_ok_s && !push_ok_s) begin
         count_nxt = count_r - (ADDR_W+1)'(1);
      end else begin
         count_nxt = count_r;
      end
   end

   // Pointers, occupancy and full flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= ADDR_W'(0);
         rd_ptr_r <= ADDR_W'(0);
         count_r  <= (ADDR_W+1)'(0);
         full_r   <= 1'b0;
      end else if (clk_en) begin
         if (clear) begin
            wr_ptr_r <= ADDR_W'(0);
            rd_ptr_r <= ADDR_W'(0);
         end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
         end
         count_r <= count_nxt;
         full_r  <= (count_nxt == (ADDR_W+1)'(DEPTH));
      end
   end

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (clk_en && !clear && push_ok_s) mem_r[wr_ptr_r] <= wdata;
   end

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;
   assign full  = full_r;
   assign empty = (count_r == (ADDR_W+1)'(0));

endmodule

// File: rtl/pe_cmd_feeder.sv
// Replays queued (opcode, operand) pairs onto the PE start/done handshake and
// holds READ results until acknowledged; isolates CPU issue rate from PE latency.
module pe_cmd_feeder
   import pe_cmd_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int OP_W    = 3,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_en,
   input  logic              clear,
   input  logic              push,
   input  logic [OP_W-1:0]   push_op,
   input  logic [DATA_W-1:0] push_data,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              pe_start,
   output logic [OP_W-1:0]   pe_n,
   output logic [DATA_W-1:0] pe_dataa,
   input  logic              pe_done,
   input  logic [DATA_W-1:0] pe_result,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              rd_ack,
   output logic              busy,
   output logic              err_overflow,
   output logic              err_opcode,
   output logic              err_timeout
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   state_e              state_r, state_nxt;
   logic                pe_start_r, start_nxt;
   logic [OP_W-1:0]     pe_n_r, n_nxt;
   logic [DATA_W-1:0]   pe_dataa_r, dataa_nxt;
   logic [TO_W-1:0]     wait_cnt_r, wcnt_nxt;
   logic                rd_valid_r, rd_valid_nxt;
   logic [DATA_W-1:0]   rd_data_r, rd_data_nxt;
   logic                busy_r, busy_nxt;
   logic                err_ov_r, err_ov_nxt;
   logic                err_op_r, err_op_nxt;
   logic                err_to_r, err_to_nxt;

   logic [OP_W+DATA_W-1:0] head_s;
   logic [OP_W-1:0]        head_op_s;
   logic [DATA_W-1:0]      head_data_s;
   logic [ADDR_W:0]        fifo_cnt_nxt_s;
   logic                   full_s;
   logic                   empty_s;
   logic                   pop_s;
   logic                   read_stall_s;

   pe_cmd_fifo #(
      .W      (OP_W + DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clk_en    (clk_en),
      .clear     (clear),
      .push      (push),
      .pop       (pop_s),
      .wdata     ({push_op, push_data}),
      .rdata     (head_s),
      .count     (count),
      .count_nxt (fifo_cnt_nxt_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   assign head_op_s    = head_s[OP_W+DATA_W-1:DATA_W];
   assign head_data_s  = head_s[DATA_W-1:0];
   // A second READ may not overwrite an unacknowledged result.
   assign read_stall_s = (head_op_s == OP_READ) && rd_valid_r && !rd_ack;

   // Sequencer next state, handshake outputs, result capture and sticky errors.
   always_comb begin
      state_nxt    = state_r;
      start_nxt    = pe_start_r;
      n_nxt        = pe_n_r;
      dataa_nxt    = pe_dataa_r;
      wcnt_nxt     = wait_cnt_r;
      rd_data_nxt  = rd_data_r;
      pop_s        = 1'b0;
      err_op_nxt   = err_op_r;
      err_to_nxt   = err_to_r;
      rd_valid_nxt = rd_valid_r & ~rd_ack;
      err_ov_nxt   = err_ov_r | (push & full_s);
      case (state_r)
         ST_IDLE: begin
            if (!empty_s && !read_stall_s) begin
               pop_s     = 1'b1;
               n_nxt     = head_op_s;
               dataa_nxt = head_data_s;
               if (is_write(head_op_s) || (head_op_s == OP_READ)) begin
                  state_nxt = ST_ISSUE;
                  start_nxt = 1'b1;
               end else begin
                  err_op_nxt = err_op_r | is_reserved(head_op_s);
               end
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_nxt = ST_WAIT;
            wcnt_nxt  = TO_W'(0);
         end
         ST_WAIT: begin
            if (pe_done) begin
               state_nxt = ST_GAP;
               start_nxt = 1'b0;
               if (pe_n_r == OP_READ) begin
                  rd_valid_nxt = 1'b1;
                  rd_data_nxt  = pe_result;
               end else begin
                  rd_data_nxt = rd_data_r;
               end
            end else if (wait_cnt_r == TO_W'(TIMEOUT - 1)) begin
               state_nxt  = ST_GAP;
               start_nxt  = 1'b0;
               err_to_nxt = 1'b1;
            end else begin
               wcnt_nxt = wait_cnt_r + TO_W'(1);
            end
         end
         ST_GAP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            start_nxt = 1'b0;
         end
      endcase
      busy_nxt = (state_nxt != ST_IDLE) || (fifo_cnt_nxt_s != (ADDR_W+1)'(0));
   end

   // State and output registers; clear mirrors reset, clk_en low freezes all.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         pe_start_r <= 1'b0;
         pe_n_r     <= OP_NOP;
         pe_dataa_r <= DATA_W'(0);
         wait_cnt_r <= TO_W'(0);
         rd_valid_r <= 1'b0;
         rd_data_r  <= DATA_W'(0);
         busy_r     <= 1'b0;
         err_ov_r   <= 1'b0;
         err_op_r   <= 1'b0;
         err_to_r   <= 1'b0;
      end else if (clk_en) begin
         if (clear) begin
            state_r    <= ST_IDLE;
            pe_start_r <= 1'b0;
            pe_n_r     <= OP_NOP;
            pe_dataa_r <= DATA_W'(0);
            wait_cnt_r <= TO_W'(0);
            rd_valid_r <= 1'b0;
            rd_data_r  <= DATA_W'(0);
            busy_r     <= 1'b0;
            err_ov_r   <= 1'b0;
            err_op_r   <= 1'b0;
            err_to_r   <= 1'b0;
         end else begin
            state_r    <= state_nxt;
            pe_start_r <= start_nxt;
            pe_n_r     <= n_nxt;
            pe_dataa_r <= dataa_nxt;
            wait_cnt_r <= wcnt_nxt;
            rd_valid_r <= rd_valid_nxt;
            rd_data_r  <= rd_data_nxt;
            busy_r     <= busy_nxt;
            err_ov_r   <= err_ov_nxt;
            err_op_r   <= err_op_nxt;
            err_to_r   <= err_to_nxt;
         end
      end
   end

   assign full         = full_s;
   assign pe_start     = pe_start_r;
   assign pe_n         = pe_n_r;
   assign pe_dataa     = pe_dataa_r;
   assign rd_valid     = rd_valid_r;
   assign rd_data      = rd_data_r;
   assign busy         = busy_r;
   assign err_overflow = err_ov_r;
   assign err_opcode   = err_op_r;
   assign err_timeout  = err_to_r;

endmodule
